// File: rtl/ws_multi_lane_pe.sv
// Weight-stationary multi-lane PE: double-buffered weights, registered inputs,
// and an exact lane dot-product plus upstream psum, converted by saturation or wrap.
module ws_multi_lane_pe #(
  parameter int LANES            = 4,
  parameter int INPUT_WIDTH      = 16,
  parameter int INPUT_INT_WIDTH  = 8,
  parameter int WEIGHT_WIDTH     = 8,
  parameter int WEIGHT_INT_WIDTH = 2,
  parameter int PSUM_WIDTH       = INPUT_WIDTH + WEIGHT_WIDTH,
  parameter int SAT_EN           = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            iclr,
  input  logic                            wclr,
  input  logic                            iload_i_valid,
  input  logic                            wload_i_valid,
  input  logic                            wswap_i,
  input  logic [LANES*INPUT_WIDTH-1:0]    if_i_data,
  input  logic [LANES*WEIGHT_WIDTH-1:0]   weight_i_data,
  input  logic [PSUM_WIDTH-1:0]           psum_i_data,
  output logic                            iload_o_valid,
  output logic [LANES*INPUT_WIDTH-1:0]    if_o_data,
  output logic [LANES*WEIGHT_WIDTH-1:0]   weight_o_data,
  output logic [PSUM_WIDTH-1:0]           psum_o_data,
  output logic                            psum_o_valid,
  output logic                            ovf_o
);

  localparam int PROD_W    = INPUT_WIDTH + WEIGHT_WIDTH;
  localparam int SUM_W     = PSUM_WIDTH + $clog2(LANES + 1);
  localparam int TOP_W     = SUM_W - PSUM_WIDTH + 1;
  localparam int PSUM_INT  = INPUT_INT_WIDTH + WEIGHT_INT_WIDTH;
  localparam int PROD_FRAC = (INPUT_WIDTH - INPUT_INT_WIDTH) + (WEIGHT_WIDTH - WEIGHT_INT_WIDTH);

  // Products are added without realignment, so the psum binary point must match theirs.
  if ((PSUM_WIDTH - PSUM_INT) != PROD_FRAC || PSUM_WIDTH < PROD_W) begin : g_bad_format
    $error("ws_multi_lane_pe: psum format does not match the product format");
  end

  logic [LANES*INPUT_WIDTH-1:0]  if_reg;
  logic [LANES*WEIGHT_WIDTH-1:0] shadow_bank;
  logic [LANES*WEIGHT_WIDTH-1:0] active_bank;

  logic signed [PROD_W-1:0] prod [LANES];
  logic signed [SUM_W-1:0]  sum_exact;
  logic [TOP_W-1:0]         top_bits;
  logic                     out_of_range;
  logic [PSUM_WIDTH-1:0]    sat_val;
  logic [PSUM_WIDTH-1:0]    psum_next;

  always_comb begin
    sum_exact = SUM_W'($signed(psum_i_data));
    for (int k = 0; k < LANES; k++) begin
      prod[k] = PROD_W'($signed(if_reg[k*INPUT_WIDTH +: INPUT_WIDTH])) *
                PROD_W'($signed(active_bank[k*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
      sum_exact = sum_exact + SUM_W'(prod[k]);
    end
  end

  // In range exactly when every bit above the psum sign bit equals it.
  always_comb begin
    top_bits     = sum_exact[SUM_W-1:PSUM_WIDTH-1];
    out_of_range = !((&top_bits) || (~|top_bits));
    sat_val      = sum_exact[SUM_W-1] ? {1'b1, {(PSUM_WIDTH-1){1'b0}}}
                                      : {1'b0, {(PSUM_WIDTH-1){1'b1}}};
    psum_next    = ((SAT_EN != 0) && out_of_range) ? sat_val : sum_exact[PSUM_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_reg        <= '0;
      iload_o_valid <= 1'b0;
      psum_o_valid  <= 1'b0;
      psum_o_data   <= '0;
      ovf_o         <= 1'b0;
    end else begin
      if (iclr) begin
        if_reg        <= '0;
        iload_o_valid <= 1'b0;
        psum_o_valid  <= 1'b0;
        ovf_o         <= 1'b0;
      end else begin
        if (iload_i_valid) if_reg <= if_i_data;
        iload_o_valid <= iload_i_valid;
        psum_o_valid  <= iload_o_valid;
        if (out_of_range) ovf_o <= 1'b1;
      end
      if (iclr || wclr) psum_o_data <= '0;
      else              psum_o_data <= psum_next;
    end
  end

  // Swap reads the pre-edge shadow, so load and swap together move the old shadow up.
  always_ff @(posedge clk) begin
    if (!rst_n || wclr) begin
      shadow_bank <= '0;
      active_bank <= '0;
    end else begin
      if (wload_i_valid) shadow_bank <= weight_i_data;
      if (wswap_i)       active_bank <= shadow_bank;
    end
  end

  assign if_o_data     = if_reg;
  assign weight_o_data = shadow_bank;

endmodule

// File: doc/ws_multi_lane_pe.md
WS_MULTI_LANE_PE -- requirements
Module: ws_multi_lane_pe

Interface
REQ-001 SHALL have parameter LANES, default 4; number of parallel input/weight lanes, 1..16.
REQ-002 SHALL have parameter INPUT_WIDTH, default 16, and INPUT_INT_WIDTH, default 8; per-lane input format Q8.8, signed.
REQ-003 SHALL have parameter WEIGHT_WIDTH, default 8, and WEIGHT_INT_WIDTH, default 2; per-lane weight format Q2.6, signed.
REQ-004 SHALL have parameter PSUM_WIDTH, default INPUT_WIDTH+WEIGHT_WIDTH; psum format is Q(INPUT_INT_WIDTH+WEIGHT_INT_WIDTH).(rest), signed.
REQ-005 SHALL have parameter SAT_EN, default 1; 1 means saturate psum, 0 means two's-complement wrap.
REQ-006 clk  in  1  clock; one clock domain, all state updates on its rising edge.
REQ-007 rst_n  in  1  reset; synchronous and active-low.
REQ-008 iclr  in  1  synchronous input/psum clear, active high.
REQ-009 wclr  in  1  synchronous clear of both weight banks, active high.
REQ-010 iload_i_valid  in  1  input lanes valid.
REQ-011 wload_i_valid  in  1  write weight_i_data into the shadow bank.
REQ-012 wswap_i  in  1  promote shadow bank to active bank.
REQ-013 if_i_data  in  LANES*INPUT_WIDTH  packed inputs; lane k at bits [k*INPUT_WIDTH +: INPUT_WIDTH].
REQ-014 weight_i_data  in  LANES*WEIGHT_WIDTH  packed weights, lane order as REQ-013.
REQ-015 psum_i_data  in  PSUM_WIDTH  upstream partial sum.
REQ-016 iload_o_valid, if_o_data  out  1, LANES*INPUT_WIDTH  registered input valid and data, forwarded to the neighbour PE.
REQ-017 weight_o_data  out  LANES*WEIGHT_WIDTH  shadow bank contents, forwarded for daisy-chain weight loading.
REQ-018 psum_o_data, psum_o_valid  out  PSUM_WIDTH, 1  registered partial sum and its valid.
REQ-019 ovf_o  out  1  sticky flag: saturation or wrap occurred.

Function
REQ-020 Stage 1: on iload_i_valid=1 if_reg SHALL capture if_i_data; otherwise it holds. iload_o_valid SHALL follow iload_i_valid one cycle later.
REQ-021 On wload_i_valid=1 the shadow bank SHALL capture weight_i_data. On wswap_i=1 the active bank SHALL take the shadow value present before the edge.
REQ-022 Simultaneous wload_i_valid and wswap_i: active SHALL take the old shadow, and shadow SHALL take the new weight_i_data.
REQ-023 Stage 2 products SHALL be formed per lane as signed if_reg[k] * active[k], INPUT_WIDTH+WEIGHT_WIDTH bits, with no truncation.
REQ-024 The lane products and psum_i_data SHALL be summed exactly in PSUM_WIDTH+clog2(LANES+1) bits. psum_i_data SHALL be sampled in the cycle iload_o_valid=1.
REQ-025 Conversion to PSUM_WIDTH: with SAT_EN=1, the exact sum SHALL clamp to the signed max/min. With SAT_EN=0 the low bits SHALL be kept. In both cases ovf_o SHALL set if the exact sum is out of range.
REQ-026 The REQ-025 result SHALL be registered into psum_o_data every cycle.
REQ-027 psum_o_valid SHALL equal iload_o_valid delayed one cycle, giving latency 2 cycles from iload_i_valid to psum_o_valid.
REQ-028 iclr SHALL zero if_reg, iload_o_valid, psum_o_data, psum_o_valid and ovf_o. It SHALL have priority over iload_i_valid.
REQ-029 wclr SHALL zero both weight banks and psum_o_data. It SHALL have priority over wload_i_valid and wswap_i.
REQ-030 ovf_o SHALL remain set until iclr or reset.

Reset
REQ-031 With rst_n=0 at a clock edge, every register SHALL become 0: if_reg, both banks, iload_o_valid, psum_o_data, psum_o_valid, ovf_o. Reset SHALL take priority over iclr, wclr and all loads.
REQ-032 Reset mid-pipeline SHALL discard in-flight data; no psum_o_valid pulse SHALL follow the release of reset.

Verification
REQ-033 Basic MAC, LANES=4: all inputs 0x0100, weights 0x40 loaded then swapped, psum_i 0, one iload_i_valid pulse -> exactly two cycles later psum_o_valid=1, psum_o_data=0x010000, ovf_o=0.
REQ-034 Saturation, SAT_EN=1: inputs 0x7FFF, weights 0x7F, psum_i 0x7FFFFF -> psum_o_data=0x7FFFFF, ovf_o=1 and held until iclr. With SAT_EN=0 the same stimulus -> low 24 bits of the exact sum, ovf_o=1.
REQ-035 Double buffer: active weights 0x40; load 0xC0 into shadow without swap; compute with input 0x0100 -> lane product +0x4000. Swap, then compute -> -0x4000 per lane. weight_o_data=0xC0 per lane after the load.
REQ-036 Simultaneous wload_i_valid (0x20) and wswap_i with shadow 0x40 -> active=0x40, shadow=0x20.
REQ-037 Reset mid-pipeline: iload_i_valid pulse, then rst_n=0 on the next edge -> all outputs 0 and no later psum_o_valid pulse. An iclr pulse at the same point -> same result.
REQ-038 Back-to-back valids for 8 cycles with varying psum_i -> 8 consecutive psum_o_valid cycles, each result matching the reference model.
